// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer controller: parser states,
// opcodes, default geometry and the cell-address width helper.
package fb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPC   = 3'd1,
    ST_X     = 3'd2,
    ST_Y     = 3'd3,
    ST_COLOR = 3'd4,
    ST_WPEND = 3'd5,
    ST_FILL  = 3'd6
  } fb_state_e;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_FILL  = 8'h02;

  localparam int unsigned DEF_COLS = 40;
  localparam int unsigned DEF_ROWS = 30;
  localparam logic [7:0]  DEF_HDR  = 8'hA5;

  // Smallest address width (at least 1) able to index 'cells' entries.
  function automatic int unsigned cell_addr_w(input int unsigned cells);
    cell_addr_w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < cells) cell_addr_w = i + 1;
    end
  endfunction

endpackage

// File: rtl/fb_cmd_parser.sv
// Byte-stream command parser: decodes WRITE/FILL commands from the UART
// byte stream, holds the pending write and raises sticky error flags.
module fb_cmd_parser
  import fb_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter logic [7:0]  HDR    = DEF_HDR,
  parameter int unsigned ADDR_W = cell_addr_w(COLS * ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  input  logic              err_clr,
  input  logic              wr_done,
  input  logic              fill_done,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        color,
  output logic              fill_start,
  output logic              fill_active,
  output logic              busy,
  output logic              bad_cmd,
  output logic              drop_err
);

  fb_state_e         state_q, state_d;
  logic [7:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [2:0]        color_q, color_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fill_q, fill_d;
  logic              busy_q, busy_d;
  logic              bad_q, bad_d;
  logic              drop_q, drop_d;
  logic              bad_set, drop_set;

  // Next-state, operand latching and error-set decode.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    color_d    = color_q;
    addr_d     = addr_q;
    fill_d     = fill_q;
    bad_set    = 1'b0;
    drop_set   = 1'b0;
    fill_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_byte == HDR) state_d = ST_OPC;
      end
      ST_OPC: begin
        if (rx_valid) begin
          if (rx_byte == OP_WRITE) begin
            fill_d  = 1'b0;
            state_d = ST_X;
          end else if (rx_byte == OP_FILL) begin
            fill_d  = 1'b1;
            state_d = ST_COLOR;
          end else begin
            bad_set = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_X: begin
        if (rx_valid) begin
          x_d     = rx_byte;
          state_d = ST_Y;
        end
      end
      ST_Y: begin
        if (rx_valid) begin
          y_d     = rx_byte;
          state_d = ST_COLOR;
        end
      end
      ST_COLOR: begin
        if (rx_valid) begin
          if (fill_q) begin
            color_d    = rx_byte[2:0];
            fill_start = 1'b1;
            state_d    = ST_FILL;
          end else if (32'(x_q) >= COLS || 32'(y_q) >= ROWS) begin
            bad_set = 1'b1;
            state_d = ST_IDLE;
          end else begin
            color_d = rx_byte[2:0];
            addr_d  = ADDR_W'(32'(y_q) * COLS + 32'(x_q));
            state_d = ST_WPEND;
          end
        end
      end
      ST_WPEND: begin
        if (rx_valid) drop_set = 1'b1;
        if (wr_done)  state_d  = ST_IDLE;
      end
      ST_FILL: begin
        if (rx_valid)  drop_set = 1'b1;
        if (fill_done) state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flags: a new set takes priority over a simultaneous clear.
  always_comb begin
    bad_d  = bad_set  | (bad_q  & ~err_clr);
    drop_d = drop_set | (drop_q & ~err_clr);
    busy_d = (state_d != ST_IDLE);
  end

  // Parser state and latches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      addr_q  <= '0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      bad_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      addr_q  <= addr_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      bad_q   <= bad_d;
      drop_q  <= drop_d;
    end
  end

  assign wr_valid    = (state_q == ST_WPEND);
  assign fill_active = (state_q == ST_FILL);
  assign wr_addr     = addr_q;
  assign color       = color_q;
  assign busy        = busy_q;
  assign bad_cmd     = bad_q;
  assign drop_err    = drop_q;

endmodule

// File: rtl/fb_ctrl.sv
// Frame-buffer controller top: command parser plus the cell-RAM
// arbitration (scanout reads always win), fill counter and read valid.
module fb_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter logic [7:0]  HDR    = DEF_HDR,
  parameter int unsigned ADDR_W = cell_addr_w(COLS * ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [2:0]        rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [2:0]        mem_wdata,
  input  logic [2:0]        mem_rdata,
  output logic              busy,
  input  logic              err_clr,
  output logic              bad_cmd,
  output logic              drop_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  logic              wr_valid, fill_start, fill_active;
  logic              wr_done, fill_done;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        color;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rd_valid_q;

  fb_cmd_parser #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .HDR    (HDR),
    .ADDR_W (ADDR_W)
  ) u_parser (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .err_clr     (err_clr),
    .wr_done     (wr_done),
    .fill_done   (fill_done),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .color       (color),
    .fill_start  (fill_start),
    .fill_active (fill_active),
    .busy        (busy),
    .bad_cmd     (bad_cmd),
    .drop_err    (drop_err)
  );

  // A write or fill step only completes in a cycle the scanout leaves free.
  assign wr_done   = wr_valid & ~rd_req;
  assign fill_done = fill_active & ~rd_req & (cnt_q == LAST_ADDR);

  // Fill counter: cleared when a fill starts, advances on each issued write.
  always_comb begin
    cnt_d = cnt_q;
    if (fill_start)                 cnt_d = '0;
    else if (fill_active && !rd_req) cnt_d = cnt_q + 1'b1;
  end

  // Counter and read-valid registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_req;
    end
  end

  // RAM port arbitration: read, else pending write, else fill, else idle.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (rd_req) begin
      mem_addr = rd_addr;
    end else if (wr_valid) begin
      mem_addr  = wr_addr;
      mem_we    = 1'b1;
      mem_wdata = color;
    end else if (fill_active) begin
      mem_addr  = cnt_q;
      mem_we    = 1'b1;
      mem_wdata = color;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = mem_rdata;

endmodule

// File: tb/tb_fb_ctrl.sv
// Self-checking bench for fb_ctrl with a behavioural cell RAM and a
// reference image of the frame buffer.
module tb_fb_ctrl;
  import fb_pkg::*;

  localparam int unsigned COLS  = 40;
  localparam int unsigned ROWS  = 30;
  localparam int unsigned CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rd_req;
  logic [10:0] rd_addr;
  logic [2:0]  rd_data;
  logic        rd_valid;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata;
  logic        busy;
  logic        err_clr;
  logic        bad_cmd;
  logic        drop_err;

  always #5 clk = ~clk;

  fb_ctrl #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .HDR    (8'hA5),
    .ADDR_W (11)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err_clr   (err_clr),
    .bad_cmd   (bad_cmd),
    .drop_err  (drop_err)
  );

  // Single-port RAM with one-cycle synchronous read.
  logic [2:0] ram [0:2047];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int          checks = 0;
  int          errors = 0;
  logic [13:0] wlog[$];
  logic        prev_rq = 1'b0;
  logic [2:0]  exp_rd  = '0;
  logic [2:0]  ref_mem [0:CELLS-1];
  logic        ref_bad;

  typedef struct {
    logic [7:0]  x, y, c;
    logic        ok;
    logic [10:0] addr;
    logic [2:0]  data;
  } wvec_t;
  wvec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, observe mid-cycle, return just after the edge.
  task automatic step(input logic v, input logic [7:0] b, input logic rq,
                      input logic [10:0] ra, input logic ec);
    rx_valid = v; rx_byte = b; rd_req = rq; rd_addr = ra; err_clr = ec;
    @(negedge clk);
    chk("rd_valid", 32'(rd_valid), 32'(prev_rq));
    if (prev_rq) chk("rd_data", 32'(rd_data), 32'(exp_rd));
    if (rq) begin
      chk("rd_grant", {20'd0, mem_we, mem_addr}, {20'd0, 1'b0, ra});
      exp_rd = ram[ra];
    end
    if (mem_we) wlog.push_back({mem_addr, mem_wdata});
    prev_rq = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 11'd0, 1'b0);
  endtask

  task automatic rand_idle();
    step(1'b0, 8'h00, ($urandom_range(0, 3) == 0), 11'($urandom_range(0, CELLS - 1)), 1'b0);
  endtask

  // Byte with random idle gaps and random scanout reads around it.
  task automatic send_r(input logic [7:0] b);
    int unsigned g = $urandom_range(0, 2);
    for (int unsigned i = 0; i < g; i++) rand_idle();
    step(1'b1, b, ($urandom_range(0, 3) == 0), 11'($urandom_range(0, CELLS - 1)), 1'b0);
  endtask

  task automatic wait_idle(input logic rnd);
    int n = 0;
    while (busy && n < 3000) begin
      if (rnd) rand_idle();
      else     step(1'b0, 8'h00, 1'b0, 11'd0, 1'b0);
      n++;
    end
    chk("idle_timeout", 32'(n < 3000), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, reads, bad;
    logic [13:0] e;

    // ---------------- reset state ----------------
    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = '0; rd_req = 1'b0; rd_addr = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bad", 32'(bad_cmd), 0);
    chk("rst_drop", 32'(drop_err), 0);
    chk("rst_mem", {18'd0, mem_we, mem_addr, mem_wdata}, 0);

    // ---------------- table of WRITE commands ----------------
    tbl[0] = '{x:8'd5,   y:8'd3,   c:8'h06, ok:1'b1, addr:11'd125,  data:3'b110};
    tbl[1] = '{x:8'd0,   y:8'd0,   c:8'hFF, ok:1'b1, addr:11'd0,    data:3'b111};
    tbl[2] = '{x:8'd39,  y:8'd29,  c:8'h01, ok:1'b1, addr:11'd1199, data:3'b001};
    tbl[3] = '{x:8'd39,  y:8'd0,   c:8'hF2, ok:1'b1, addr:11'd39,   data:3'b010};
    tbl[4] = '{x:8'd0,   y:8'd29,  c:8'h0C, ok:1'b1, addr:11'd1160, data:3'b100};
    tbl[5] = '{x:8'd40,  y:8'd0,   c:8'h03, ok:1'b0, addr:11'd0,    data:3'b000};
    tbl[6] = '{x:8'd0,   y:8'd30,  c:8'h03, ok:1'b0, addr:11'd0,    data:3'b000};
    tbl[7] = '{x:8'd255, y:8'd255, c:8'h05, ok:1'b0, addr:11'd0,    data:3'b000};
    for (int i = 0; i < 8; i++) begin
      wlog.delete();
      send(8'hA5);
      chk("busy_opc", 32'(busy), 1);
      send(8'h01); send(tbl[i].x); send(tbl[i].y); send(tbl[i].c);
      step(1'b0, 8'h00, 1'b0, 11'd0, 1'b0);
      chk("wr_latency", wlog.size(), tbl[i].ok ? 1 : 0);
      if (tbl[i].ok && wlog.size() > 0) chk("wr_entry", 32'(wlog[0]), 32'({tbl[i].addr, tbl[i].data}));
      step(1'b0, 8'h00, 1'b0, 11'd0, 1'b0);
      chk("wr_once", wlog.size(), tbl[i].ok ? 1 : 0);
      chk("wr_busy", 32'(busy), 0);
      chk("wr_bad", 32'(bad_cmd), tbl[i].ok ? 0 : 1);
      step(1'b0, 8'h00, 1'b0, 11'd0, 1'b1);
      chk("wr_errclr", 32'(bad_cmd), 0);
    end

    // ---------------- WRITE held off by 4 read cycles ----------------
    wlog.delete();
    send(8'hA5); send(8'h01); send(8'h05); send(8'h03); send(8'h06);
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, 11'(100 + k), 1'b0);
    chk("held_nowrite", wlog.size(), 0);
    chk("held_busy", 32'(busy), 1);
    chk("held_rdvalid", 32'(rd_valid), 1);
    step(1'b0, 8'h00, 1'b0, 11'd0, 1'b0);
    chk("held_write", wlog.size(), 1);
    if (wlog.size() > 0) chk("held_entry", 32'(wlog[0]), 32'({11'd125, 3'b110}));
    chk("held_done", 32'(busy), 0);

    // ---------------- FILL with a read every 16th cycle ----------------
    wlog.delete();
    send(8'hA5); send(8'h02); send(8'h07);
    n = 0; reads = 0;
    do begin
      step(1'b0, 8'h00, (n % 16 == 15), 11'(n % CELLS), 1'b0);
      if (n % 16 == 15) reads++;
      n++;
    end while (busy && n < 5000);
    chk("fill_cycles", n, CELLS + reads);
    chk("fill_writes", wlog.size(), CELLS);
    bad = 0;
    for (int i = 0; i < wlog.size(); i++)
      if (wlog[i] !== {11'(i), 3'b111}) bad++;
    chk("fill_order", bad, 0);
    for (int i = 0; i < CELLS; i++) ref_mem[i] = 3'b111;

    // ---------------- bad coordinate / bad opcode ----------------
    wlog.delete();
    send(8'hA5); send(8'h01); send(8'h28); send(8'h00); send(8'h01);
    step(1'b0, 8'h00, 1'b0, 11'd0, 1'b0);
    chk("badx_nowrite", wlog.size(), 0);
    chk("badx_flag", 32'(bad_cmd), 1);
    send(8'hA5); send(8'h09);
    step(1'b0, 8'h00, 1'b0, 11'd0, 1'b0);
    chk("badop_sticky", 32'(bad_cmd), 1);
    chk("badop_idle", 32'(busy), 0);
    step(1'b0, 8'h00, 1'b0, 11'd0, 1'b1);
    chk("bad_clear", 32'(bad_cmd), 0);

    // ---------------- drops during FILL ----------------
    wlog.delete();
    send(8'hA5); send(8'h02); send(8'h03);
    n = 0;
    do begin
      step((n == 100 || n == 200), 8'hA5, 1'b0, 11'd0, (n == 150 || n == 200));
      if (n == 100) chk("drop_set", 32'(drop_err), 1);
      if (n == 150) chk("drop_clr", 32'(drop_err), 0);
      if (n == 200) chk("drop_vs_clr", 32'(drop_err), 1);
      n++;
    end while (busy && n < 5000);
    chk("drop_fill_len", n, CELLS);
    chk("drop_fill_writes", wlog.size(), CELLS);
    chk("drop_nobad", 32'(bad_cmd), 0);
    step(1'b0, 8'h00, 1'b0, 11'd0, 1'b1);
    chk("drop_clear", 32'(drop_err), 0);
    for (int i = 0; i < CELLS; i++) ref_mem[i] = 3'b011;

    // ---------------- reset at fill address 600 ----------------
    wlog.delete();
    send(8'hA5); send(8'h02); send(8'h05);
    repeat (600) step(1'b0, 8'h00, 1'b0, 11'd0, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 8'h00, 1'b0, 11'd0, 1'b0);
    rst_n = 1'b1;
    chk("rstfill_busy", 32'(busy), 0);
    chk("rstfill_we", 32'(mem_we), 0);
    chk("rstfill_addr", 32'(mem_addr), 0);
    step(1'b0, 8'h00, 1'b0, 11'd0, 1'b0);
    chk("rstfill_writes", wlog.size(), 601);
    for (int i = 0; i <= 600; i++) ref_mem[i] = 3'b101;
    wlog.delete();
    send(8'hA5); send(8'h01); send(8'h05); send(8'h03); send(8'h06);
    step(1'b0, 8'h00, 1'b0, 11'd0, 1'b0);
    chk("postrst_write", wlog.size(), 1);
    if (wlog.size() > 0) chk("postrst_entry", 32'(wlog[0]), 32'({11'd125, 3'b110}));
    ref_mem[125] = 3'b110;

    // ---------------- randomized commands vs reference image ----------------
    ref_bad = 1'b0;
    for (int it = 0; it < 150; it++) begin
      int unsigned kind = $urandom_range(0, 9);
      logic [7:0] b, x, y, c;
      logic exp_w;
      wlog.delete();
      exp_w = 1'b0;
      e = '0;
      if (kind == 0) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        send_r(b);
      end else if (kind == 1) begin
        b = 8'($urandom);
        if (b == 8'h01 || b == 8'h02) b = 8'h33;
        send_r(8'hA5); send_r(b);
        ref_bad = 1'b1;
      end else if (kind == 2) begin
        step(1'b0, 8'h00, 1'b0, 11'd0, 1'b1);
        ref_bad = 1'b0;
      end else begin
        x = 8'($urandom_range(0, 44));
        y = 8'($urandom_range(0, 33));
        c = 8'($urandom);
        send_r(8'hA5); send_r(8'h01); send_r(x); send_r(y); send_r(c);
        if (x < COLS && y < ROWS) begin
          exp_w = 1'b1;
          e = {11'(int'(y) * COLS + int'(x)), c[2:0]};
          ref_mem[int'(y) * COLS + int'(x)] = c[2:0];
        end else begin
          ref_bad = 1'b1;
        end
      end
      wait_idle(1'b1);
      chk("rnd_writes", wlog.size(), exp_w ? 1 : 0);
      if (exp_w && wlog.size() > 0) chk("rnd_entry", 32'(wlog[0]), 32'(e));
      chk("rnd_bad", 32'(bad_cmd), 32'(ref_bad));
      chk("rnd_drop", 32'(drop_err), 0);
    end

    // ---------------- final frame-buffer image ----------------
    bad = 0;
    for (int i = 0; i < CELLS; i++)
      if (ram[i] !== ref_mem[i]) bad++;
    chk("ram_image", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
